// File: rtl/nivel_vehiculos_param.sv
// Parametrised vehicle-lane bank: loads per-level patterns and rotates lanes on game steps.
// Optional NVP_COLLISION_EN adds frog position inputs and a registered hit flag.
module nivel_vehiculos_param #(
    parameter int LANES      = 6,
    parameter int W          = 8,
    parameter int NUM_LEVELS = 4,
    parameter logic [LANES*W*NUM_LEVELS-1:0] PATTERNS = '0,
    parameter logic [LANES-1:0] DIR_MASK = LANES'({(LANES+1)/2{2'b10}}),
    localparam int NVW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int LW  = $clog2(LANES + 1),
    localparam int CW  = (W > 1) ? $clog2(W) : 1
) (
    input  logic               NVP_CLOCK,
    input  logic               NVP_RESET,
    input  logic               NVP_LOAD_IN,
    input  logic               NVP_RUN_IN,
    input  logic [NVW-1:0]     NVP_NV_IN,
    input  logic               NVP_CN_IN,
`ifdef NVP_COLLISION_EN
    input  logic [LW-1:0]      NVP_FROG_LANE_IN,
    input  logic [CW-1:0]      NVP_FROG_COL_IN,
    output logic               NVP_HIT_OUT,
`endif
    output logic [LANES*W-1:0] NVP_LANES_OUT,
    output logic               NVP_STEP_OUT,
    output logic               NVP_RUNNING_OUT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [LANES*W-1:0] lanes_q, lanes_d;
    logic [NVW-1:0]     level_q, level_d;
    logic [NVW-1:0]     div_q, div_d;
    logic               step_q, step_d;
    logic               running_q;
    logic [NVW-1:0]     nv_clamped;
    logic [NVW-1:0]     period_m1;

    // Circular 1-bit rotations written as shifts so that W=1 degenerates to identity.
    function automatic logic [W-1:0] rot_r(input logic [W-1:0] v);
        return (v >> 1) | (v << (W - 1));
    endfunction

    function automatic logic [W-1:0] rot_l(input logic [W-1:0] v);
        return (v << 1) | (v >> (W - 1));
    endfunction

    assign nv_clamped = (int'(NVP_NV_IN) >= NUM_LEVELS) ? NVW'(NUM_LEVELS - 1) : NVP_NV_IN;
    assign period_m1  = NVW'(NUM_LEVELS - 1 - int'(level_q));

    always_comb begin
        state_d = state_q;
        lanes_d = lanes_q;
        level_d = level_q;
        div_d   = div_q;
        step_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (NVP_LOAD_IN) begin
                    state_d = S_LOAD;
                    level_d = nv_clamped;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < LANES; i++) begin
                    lanes_d[i*W +: W] = PATTERNS[(int'(level_q)*LANES + i)*W +: W];
                end
                div_d   = '0;
                state_d = NVP_RUN_IN ? S_RUN : S_HOLD;
            end
            S_RUN: begin
                if (NVP_LOAD_IN) begin
                    state_d = S_LOAD;
                    level_d = nv_clamped;
                end else begin
                    if (NVP_CN_IN) begin
                        if (div_q == period_m1) begin
                            for (int i = 0; i < LANES; i++) begin
                                lanes_d[i*W +: W] = DIR_MASK[i] ? rot_r(lanes_q[i*W +: W])
                                                                : rot_l(lanes_q[i*W +: W]);
                            end
                            div_d  = '0;
                            step_d = 1'b1;
                        end else begin
                            div_d = div_q + NVW'(1);
                        end
                    end
                    if (!NVP_RUN_IN) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (NVP_LOAD_IN) begin
                    state_d = S_LOAD;
                    level_d = nv_clamped;
                end else if (NVP_RUN_IN) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge NVP_CLOCK) begin
        if (!NVP_RESET) begin
            state_q   <= S_IDLE;
            lanes_q   <= '0;
            level_q   <= '0;
            div_q     <= '0;
            step_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lanes_q   <= lanes_d;
            level_q   <= level_d;
            div_q     <= div_d;
            step_q    <= step_d;
            running_q <= (state_d == S_RUN);
        end
    end

    assign NVP_LANES_OUT   = lanes_q;
    assign NVP_STEP_OUT    = step_q;
    assign NVP_RUNNING_OUT = running_q;

`ifdef NVP_COLLISION_EN
    logic hit_q, hit_d;

    always_comb begin
        hit_d = 1'b0;
        if ((state_q == S_RUN || state_q == S_HOLD) &&
            int'(NVP_FROG_LANE_IN) < LANES && int'(NVP_FROG_COL_IN) < W) begin
            hit_d = lanes_q[int'(NVP_FROG_LANE_IN)*W + int'(NVP_FROG_COL_IN)];
        end
    end

    always_ff @(posedge NVP_CLOCK) begin
        if (!NVP_RESET) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign NVP_HIT_OUT = hit_q;
`endif

endmodule

// File: tb/tb_nivel_vehiculos_param.sv
// Scoreboard bench for nivel_vehiculos_param (2 lanes, 8 columns, 2 levels).
// Build with +define+NVP_COLLISION_EN to also exercise the hit flag.
module tb_nivel_vehiculos_param;

    localparam int LANES = 2;
    localparam int W     = 8;
    localparam int NL    = 2;
    // level1: lane1=80 lane0=01 ; level0: lane1=03 lane0=C0
    localparam logic [LANES*W*NL-1:0] PAT = 32'h8001_03C0;

    logic        clk = 1'b0;
    logic        rst_n, load, run, cn;
    logic [0:0]  nv;
    logic [15:0] lanes;
    logic        step, running;
`ifdef NVP_COLLISION_EN
    logic [1:0]  frog_lane;
    logic [2:0]  frog_col;
    logic        hit;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    nivel_vehiculos_param #(
        .LANES(LANES), .W(W), .NUM_LEVELS(NL), .PATTERNS(PAT)
    ) dut (
        .NVP_CLOCK(clk),
        .NVP_RESET(rst_n),
        .NVP_LOAD_IN(load),
        .NVP_RUN_IN(run),
        .NVP_NV_IN(nv),
        .NVP_CN_IN(cn),
`ifdef NVP_COLLISION_EN
        .NVP_FROG_LANE_IN(frog_lane),
        .NVP_FROG_COL_IN(frog_col),
        .NVP_HIT_OUT(hit),
`endif
        .NVP_LANES_OUT(lanes),
        .NVP_STEP_OUT(step),
        .NVP_RUNNING_OUT(running)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        cn = 1'b1;
        tick();
        cn = 1'b0;
        tick();
    endtask

    task automatic do_load(input logic [0:0] lvl);
        load = 1'b1;
        nv   = lvl;
        tick();
        load = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        run   = 1'b0;
        nv    = '0;
        cn    = 1'b0;
`ifdef NVP_COLLISION_EN
        frog_lane = 2'd0;
        frog_col  = 3'd0;
`endif
        fork
            forever begin
                @(negedge clk);
                if (step === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_step", {16'h0, lanes}, 32'hFFFF_FFFF);
                    end else begin
                        chk("step_lanes", {16'h0, lanes}, {16'h0, exp_q.pop_front()});
                    end
                end
            end
        join_none

        tick(2);
        chk("rst_lanes", {16'h0, lanes}, 32'h0);
        chk("rst_step", {31'h0, step}, 32'h0);
        chk("rst_running", {31'h0, running}, 32'h0);
`ifdef NVP_COLLISION_EN
        chk("rst_hit", {31'h0, hit}, 32'h0);
`endif
        rst_n = 1'b1;
        run   = 1'b1;

        // level 0 load, period 2
        load = 1'b1;
        nv   = 1'b0;
        tick();
        chk("load_not_yet", {16'h0, lanes}, 32'h0);
        load = 1'b0;
        tick();
        chk("load_l0", {16'h0, lanes}, 32'h03C0);
        chk("running_after_load", {31'h0, running}, 32'h1);

        strobe();
        chk("div_no_rot", {16'h0, lanes}, 32'h03C0);
        exp_q.push_back(16'h8181);
        strobe();
        strobe();
        exp_q.push_back(16'hC003);
        strobe();
        chk("after_4_strobes", {16'h0, lanes}, 32'hC003);

        // level 1 load, period 1
        do_load(1'b1);
        chk("load_l1", {16'h0, lanes}, 32'h8001);
        exp_q.push_back(16'h4002);
        strobe();
        run = 1'b0;
        tick();
        chk("hold_running", {31'h0, running}, 32'h0);
        strobe();
        strobe();
        strobe();
        chk("hold_frozen", {16'h0, lanes}, 32'h4002);
        run = 1'b1;
        tick();
        chk("resume_running", {31'h0, running}, 32'h1);
        exp_q.push_back(16'h2004);
        strobe();

        // load coincident with strobe: strobe dropped
        load = 1'b1;
        nv   = 1'b0;
        cn   = 1'b1;
        tick();
        chk("load_cn_no_rot", {16'h0, lanes}, 32'h2004);
        load = 1'b0;
        cn   = 1'b0;
        tick();
        chk("reload_l0", {16'h0, lanes}, 32'h03C0);
        strobe();
        chk("div_cleared", {16'h0, lanes}, 32'h03C0);
        exp_q.push_back(16'h8181);
        strobe();

        // reset between qualifying strobes
        strobe();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_lanes", {16'h0, lanes}, 32'h0);
        chk("mid_rst_running", {31'h0, running}, 32'h0);
        chk("mid_rst_step", {31'h0, step}, 32'h0);
        strobe();
        strobe();
        chk("idle_ignores_cn", {16'h0, lanes}, 32'h0);

`ifdef NVP_COLLISION_EN
        frog_lane = 2'd0;
        frog_col  = 3'd0;
        tick();
        chk("idle_no_hit", {31'h0, hit}, 32'h0);
        do_load(1'b1);
        tick();
        chk("hit_lane0_col0", {31'h0, hit}, 32'h1);
        frog_col = 3'd1;
        tick();
        chk("miss_col1", {31'h0, hit}, 32'h0);
        frog_lane = 2'd1;
        frog_col  = 3'd7;
        tick();
        chk("hit_lane1_col7", {31'h0, hit}, 32'h1);
        frog_lane = 2'd2;
        tick();
        chk("offroad_no_hit", {31'h0, hit}, 32'h0);
`endif

        tick(3);
        chk("steps_pending", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
